// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES key-schedule generator, one 32-bit word per clock.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-high
//   start      - one-cycle request to expand key_in (ignored unless idle)
//   key_in     - cipher key, left-aligned; bits [255 -: 32*NK] are used
//   busy       - expansion in progress
//   done       - one-cycle pulse when the schedule is complete
//   key_valid  - full_key holds a complete schedule for the last accepted key
//   full_key   - round keys; round r at [128*r+127 : 128*r], w[4r] in its top word
//
// Optional build macro KEYEXP_ROUND_TAP_EN adds:
//   round_sel  - round index to tap
//   round_key  - combinational slice of full_key for round_sel; zero when
//                round_sel > NR or key_valid is low
//
// Parameters: NK (4/6/8 key words), NR and NW derived from NK.

module key_expansion_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Entry n lives at bits [8*(255-n) +: 8], i.e. entry 0x00 is the MSB byte.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module key_expansion_seq #(
  parameter int NK = 4,
  parameter int NR = NK + 6,
  parameter int NW = 4 * (NR + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [255:0]            key_in,
`ifdef KEYEXP_ROUND_TAP_EN
  input  logic [5:0]              round_sel,
  output logic [127:0]            round_key,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    key_valid,
  output logic [128*(NR+1)-1:0]   full_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

  state_t      state, stateNext;
  logic [5:0]  wordIdx;
  logic [2:0]  phase;
  logic [7:0]  rcon;
  logic [31:0] window [NK];   // window[0] = w[i-NK], window[NK-1] = w[i-1]
  logic [31:0] prevWord, subIn, subOut, temp, newWord;
  logic        unusedKeyBits;

  // Lower key_in bits are ignored for NK < 8.
  assign unusedKeyBits = ^key_in;

  // Bit offset of schedule word k: rounds ascend from the LSB, words descend within a round.
  function automatic int unsigned wordPos(input int unsigned k);
    return 128 * (k / 4) + 32 * (3 - (k % 4));
  endfunction

  for (genvar b = 0; b < 4; b++) begin : gSbox
    key_expansion_sbox uSbox (.a(subIn[8*b +: 8]), .y(subOut[8*b +: 8]));
  end

  always_comb begin
    prevWord = window[NK-1];
    subIn    = (phase == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
    temp     = prevWord;
    if (phase == 3'd0) begin
      temp = subOut ^ {rcon, 24'h000000};
    end else if (NK == 8 && phase == 3'd4) begin
      temp = subOut;
    end
    newWord = window[0] ^ temp;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = EXPAND;
      EXPAND:  if (wordIdx == 6'(NW - 1)) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      full_key  <= '0;
      wordIdx   <= '0;
      phase     <= '0;
      rcon      <= '0;
      for (int unsigned k = 0; k < NK; k++) window[k] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned k = 0; k < NK; k++) begin
              full_key[wordPos(k) +: 32] <= key_in[255 - 32*k -: 32];
              window[k]                  <= key_in[255 - 32*k -: 32];
            end
            wordIdx   <= 6'(NK);
            phase     <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXPAND: begin
          for (int unsigned k = 0; k < NW; k++) begin
            if (wordIdx == 6'(k)) full_key[wordPos(k) +: 32] <= newWord;
          end
          for (int unsigned k = 0; k < NK - 1; k++) window[k] <= window[k+1];
          window[NK-1] <= newWord;
          wordIdx      <= wordIdx + 6'd1;
          if (phase == 3'(NK - 1)) begin
            phase <= '0;
            rcon  <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          end else begin
            phase <= phase + 3'd1;
          end
        end
        FINISH: begin
          done      <= 1'b1;
          key_valid <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef KEYEXP_ROUND_TAP_EN
  always_comb begin
    round_key = '0;
    if (key_valid) begin
      for (int unsigned r = 0; r <= NR; r++) begin
        if (round_sel == 6'(r)) round_key = full_key[128*r +: 128];
      end
    end
  end
`endif

endmodule
